// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the RV32I load/store path: funct3 encodings,
// LSU state type and request legality checks.
package load_store_unit_pkg;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_RESP = 2'd2
   } lsu_state_t;

   function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
      logic ok;
      if (is_store) begin
         ok = (funct3 == FUNCT3_SB) || (funct3 == FUNCT3_SH) || (funct3 == FUNCT3_SW);
      end else begin
         ok = (funct3 == FUNCT3_LB) || (funct3 == FUNCT3_LH) || (funct3 == FUNCT3_LW) ||
              (funct3 == FUNCT3_LBU) || (funct3 == FUNCT3_LHU);
      end
      return ok;
   endfunction

   // size is funct3[1:0]: 00 byte, 01 half, 10 word
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         2'b01:   mis = addr_lo[0];
         2'b10:   mis = (addr_lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load result formatting: picks the addressed byte/half out of a bus word
// and sign- or zero-extends it according to funct3.
module load_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata32
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // lane select followed by extension
   always_comb begin
      byte_s  = 8'd0;
      half_s  = 16'd0;
      rdata32 = 32'd0;
      case (addr)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         2'd3:    byte_s = rdata[31:24];
         default: byte_s = 8'd0;
      endcase
      if (addr[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
      case (funct3)
         FUNCT3_LB:  rdata32 = {{24{byte_s[7]}}, byte_s};
         FUNCT3_LBU: rdata32 = {24'd0, byte_s};
         FUNCT3_LH:  rdata32 = {{16{half_s[15]}}, half_s};
         FUNCT3_LHU: rdata32 = {16'd0, half_s};
         FUNCT3_LW:  rdata32 = rdata;
         default:    rdata32 = 32'd0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage of the multicycle RV32I core: runs one load or store
// over a req/ack data bus and returns the formatted result with a done pulse.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        lsu_start,
   input  logic        lsu_is_store,
   input  logic [2:0]  lsu_funct3,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   output logic        lsu_busy,
   output logic        lsu_done,
   output logic [31:0] lsu_rdata,
   output logic        lsu_fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   lsu_state_t  state_r, state_s;
   logic [1:0]  addr_lo_r;
   logic [2:0]  funct3_r;
   logic        is_store_r;
   logic [31:0] cnt_r;
   logic        busy_r, done_r, req_r, we_r, fault_r;
   logic [31:0] maddr_r, wdata_r, rdata_r;
   logic [3:0]  wmask_r;
   logic        req_ok_s, timeout_s;
   logic [31:0] store_wdata_s, load_data_s;
   logic [3:0]  store_wmask_s;

   assign req_ok_s = funct3_legal(lsu_is_store, lsu_funct3) &&
                     !misaligned(lsu_funct3[1:0], lsu_addr[1:0]);

   load_align u_load_align (
      .rdata   (mem_rdata),
      .addr    (addr_lo_r),
      .funct3  (funct3_r),
      .rdata32 (load_data_s)
   );

   // store lane formatting; loads never drive lanes
   always_comb begin
      store_wdata_s = 32'd0;
      store_wmask_s = 4'd0;
      if (lsu_is_store) begin
         case (lsu_funct3)
            FUNCT3_SB: begin
               store_wdata_s = {4{lsu_wdata[7:0]}};
               store_wmask_s = 4'b0001 << lsu_addr[1:0];
            end
            FUNCT3_SH: begin
               store_wdata_s = {2{lsu_wdata[15:0]}};
               store_wmask_s = 4'b0011 << lsu_addr[1:0];
            end
            default: begin
               store_wdata_s = lsu_wdata;
               store_wmask_s = 4'b1111;
            end
         endcase
      end else begin
         store_wdata_s = 32'd0;
         store_wmask_s = 4'd0;
      end
   end

   // next-state logic; an ack in the final counted cycle still wins over timeout
   always_comb begin
      state_s   = state_r;
      timeout_s = 1'b0;
      if (TIMEOUT_CYCLES != 32'd0) begin
         timeout_s = !mem_ack && ((cnt_r + 32'd1) == TIMEOUT_CYCLES);
      end else begin
         timeout_s = 1'b0;
      end
      case (state_r)
         LSU_IDLE: begin
            if (lsu_start) begin
               state_s = req_ok_s ? LSU_REQ : LSU_RESP;
            end else begin
               state_s = LSU_IDLE;
            end
         end
         LSU_REQ: begin
            if (mem_ack || timeout_s) begin
               state_s = LSU_RESP;
            end else begin
               state_s = LSU_REQ;
            end
         end
         LSU_RESP: state_s = LSU_IDLE;
         default:  state_s = LSU_IDLE;
      endcase
   end

   // state, bus drive and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= LSU_IDLE;
         addr_lo_r  <= 2'd0;
         funct3_r   <= 3'd0;
         is_store_r <= 1'b0;
         cnt_r      <= 32'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         req_r      <= 1'b0;
         we_r       <= 1'b0;
         maddr_r    <= 32'd0;
         wdata_r    <= 32'd0;
         wmask_r    <= 4'd0;
         rdata_r    <= 32'd0;
         fault_r    <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != LSU_IDLE);
         req_r   <= (state_s == LSU_REQ);
         done_r  <= (state_s == LSU_RESP);
         case (state_r)
            LSU_IDLE: begin
               if (lsu_start) begin
                  addr_lo_r  <= lsu_addr[1:0];
                  funct3_r   <= lsu_funct3;
                  is_store_r <= lsu_is_store;
                  cnt_r      <= 32'd0;
                  rdata_r    <= 32'd0;
                  fault_r    <= ~req_ok_s;
                  if (req_ok_s) begin
                     we_r    <= lsu_is_store;
                     maddr_r <= {lsu_addr[31:2], 2'b00};
                     wdata_r <= store_wdata_s;
                     wmask_r <= store_wmask_s;
                  end
               end
            end
            LSU_REQ: begin
               if (mem_ack) begin
                  if (!is_store_r) begin
                     rdata_r <= load_data_s;
                  end
                  we_r    <= 1'b0;
                  maddr_r <= 32'd0;
                  wdata_r <= 32'd0;
                  wmask_r <= 4'd0;
               end else if (timeout_s) begin
                  fault_r <= 1'b1;
                  we_r    <= 1'b0;
                  maddr_r <= 32'd0;
                  wdata_r <= 32'd0;
                  wmask_r <= 4'd0;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign lsu_busy  = busy_r;
   assign lsu_done  = done_r;
   assign lsu_rdata = rdata_r;
   assign lsu_fault = fault_r;
   assign mem_req   = req_r;
   assign mem_we    = we_r;
   assign mem_addr  = maddr_r;
   assign mem_wdata = wdata_r;
   assign mem_wmask = wmask_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a transaction-level model predicts
// each cycle's outputs and one negedge process compares them.
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        lsu_start, lsu_is_store;
   logic [2:0]  lsu_funct3;
   logic [31:0] lsu_addr, lsu_wdata;
   logic        lsu_busy, lsu_done, lsu_fault;
   logic [31:0] lsu_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .lsu_start(lsu_start), .lsu_is_store(lsu_is_store), .lsu_funct3(lsu_funct3),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_fault(lsu_fault),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   logic chk_en = 1'b0;

   logic        exp_busy, exp_req, exp_done, exp_we, exp_fault, exp_rchk;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;
   logic [3:0]  exp_wmask;

   int          obs_req_cnt, obs_done_cyc;
   logic        obs_we;
   logic [31:0] obs_addr, obs_wdata;
   logic [3:0]  obs_wmask;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act === want) begin
         passes++;
      end else begin
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Reference load result: shift the addressed byte/half down, then extend.
   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rd);
      logic [31:0] sh;
      sh = rd >> (8 * a[1:0]);
      case (f3)
         3'd0:    return sh[7] ? (32'hFFFF_FF00 | (sh & 32'hFF)) : (sh & 32'hFF);
         3'd4:    return sh & 32'hFF;
         3'd1:    return sh[15] ? (32'hFFFF_0000 | (sh & 32'hFFFF)) : (sh & 32'hFFFF);
         3'd5:    return sh & 32'hFFFF;
         default: return rd;
      endcase
   endfunction

   task automatic set_idle();
      exp_busy = 1'b0;
      exp_req  = 1'b0;
      exp_done = 1'b0;
   endtask

   // Every cycle outputs are meaningful, compare against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", {31'd0, lsu_busy}, {31'd0, exp_busy});
         chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
         chk("done", {31'd0, lsu_done}, {31'd0, exp_done});
         if (exp_req) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, exp_wmask});
            if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
         end
         if (!exp_busy || exp_done) begin
            chk("fault", {31'd0, lsu_fault}, {31'd0, exp_fault});
            if (exp_rchk) chk("rdata", lsu_rdata, exp_rdata);
         end
      end
   end

   task automatic observe(input int c);
      if (mem_req) begin
         if (obs_req_cnt == 0) begin
            obs_we    = mem_we;
            obs_addr  = mem_addr;
            obs_wdata = mem_wdata;
            obs_wmask = mem_wmask;
         end
         obs_req_cnt++;
      end
      if (lsu_done) obs_done_cyc = c;
   endtask

   // One access; ack_dly = wait cycles before ack, negative = never ack.
   // Called at posedge+1 with the DUT idle.
   task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int ack_dly, input logic [31:0] rd);
      logic legal, mis, flt0, tmo;
      logic [1:0] sz;
      int n_req, ack_cyc;
      sz    = f3[1:0];
      legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      mis   = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
      flt0  = !legal || mis;
      tmo   = 1'b0;
      ack_cyc = -1;
      if (flt0) begin
         n_req = 0;
      end else if (ack_dly >= 0 && ack_dly + 1 <= TO) begin
         n_req   = ack_dly + 1;
         ack_cyc = n_req;
      end else begin
         n_req = TO;
         tmo   = 1'b1;
      end
      exp_we    = st;
      exp_addr  = a & 32'hFFFF_FFFC;
      exp_wmask = !st ? 4'd0 : (sz == 2'd0) ? (4'b0001 << a[1:0]) :
                  (sz == 2'd1) ? (4'b0011 << a[1:0]) : 4'b1111;
      exp_wdata = (sz == 2'd0) ? ({24'd0, wd[7:0]} * 32'h0101_0101) :
                  (sz == 2'd1) ? ({16'd0, wd[15:0]} * 32'h0001_0001) : wd;
      obs_req_cnt  = 0;
      obs_done_cyc = -1;
      obs_we = 1'b0; obs_addr = 32'd0; obs_wdata = 32'd0; obs_wmask = 4'd0;

      lsu_start = 1'b1; lsu_is_store = st; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
      mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
      set_idle();
      @(negedge clk); observe(0);
      @(posedge clk); #1;
      for (int c = 1; c <= n_req + 1; c++) begin
         lsu_start    = (c == 1) ? 1'b1 : 1'($urandom % 2);
         lsu_is_store = 1'($urandom % 2);
         lsu_funct3   = 3'($urandom);
         lsu_addr     = $urandom;
         lsu_wdata    = $urandom;
         exp_busy     = 1'b1;
         if (c <= n_req) begin
            exp_req   = 1'b1;
            exp_done  = 1'b0;
            mem_ack   = (c == ack_cyc);
            mem_rdata = (c == ack_cyc) ? rd : $urandom;
         end else begin
            exp_req   = 1'b0;
            exp_done  = 1'b1;
            exp_fault = flt0 || tmo;
            exp_rchk  = !st && (tmo || !flt0);
            exp_rdata = tmo ? 32'd0 : model_load(f3, a, rd);
            mem_ack   = 1'($urandom % 2);
            mem_rdata = $urandom;
         end
         @(negedge clk); observe(c);
         @(posedge clk); #1;
      end
      lsu_start = 1'b0;
      set_idle();
      repeat ($urandom_range(0, 2)) begin
         mem_ack = 1'($urandom % 2);
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      lsu_start = 1'b0; lsu_is_store = 1'b0; lsu_funct3 = 3'd0;
      lsu_addr = 32'd0; lsu_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
      set_idle();
      exp_we = 1'b0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_wmask = 4'd0;
      exp_fault = 1'b0; exp_rdata = 32'd0; exp_rchk = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset busy", {31'd0, lsu_busy}, 32'd0);
      chk("reset req", {31'd0, mem_req}, 32'd0);
      chk("reset done", {31'd0, lsu_done}, 32'd0);
      chk("reset rdata", lsu_rdata, 32'd0);
      chk("reset fault", {31'd0, lsu_fault}, 32'd0);
      chk("reset wmask", {28'd0, mem_wmask}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b1;

      // SB with two wait cycles
      txn(1'b1, 3'b000, 32'h0000_0103, 32'h1234_56AB, 2, 32'd0);
      chk("sb addr", obs_addr, 32'h0000_0100);
      chk("sb wmask", {28'd0, obs_wmask}, 32'h0000_0008);
      chk("sb wdata", obs_wdata, 32'hABAB_ABAB);
      chk("sb we", {31'd0, obs_we}, 32'd1);
      chk("sb done cycle", obs_done_cyc, 32'd4);
      chk("sb fault", {31'd0, lsu_fault}, 32'd0);

      txn(1'b0, 3'b000, 32'h0000_0102, 32'd0, 1, 32'h1280_FF34);
      chk("lb rdata", lsu_rdata, 32'hFFFF_FF80);
      txn(1'b0, 3'b100, 32'h0000_0102, 32'd0, 0, 32'h1280_FF34);
      chk("lbu rdata", lsu_rdata, 32'h0000_0080);
      txn(1'b0, 3'b101, 32'h0000_0100, 32'd0, 3, 32'h1280_FF34);
      chk("lhu rdata", lsu_rdata, 32'h0000_FF34);

      txn(1'b0, 3'b001, 32'h0000_0102, 32'd0, 0, 32'h8001_0000);
      chk("lh done cycle", obs_done_cyc, 32'd2);
      chk("lh rdata", lsu_rdata, 32'hFFFF_8001);

      txn(1'b0, 3'b010, 32'h0000_0101, 32'd0, 0, 32'hDEAD_BEEF);
      chk("lw misaligned req", obs_req_cnt, 32'd0);
      chk("lw misaligned done", obs_done_cyc, 32'd1);
      chk("lw misaligned fault", {31'd0, lsu_fault}, 32'd1);
      txn(1'b1, 3'b011, 32'h0000_0200, 32'h5555_AAAA, 0, 32'd0);
      chk("illegal st req", obs_req_cnt, 32'd0);
      chk("illegal st done", obs_done_cyc, 32'd1);
      chk("illegal st fault", {31'd0, lsu_fault}, 32'd1);

      // timeout, with a start pulse issued while busy
      txn(1'b0, 3'b010, 32'h0000_0400, 32'd0, -1, 32'h1111_2222);
      chk("timeout req cycles", obs_req_cnt, 32'd4);
      chk("timeout done cycle", obs_done_cyc, 32'd5);
      chk("timeout fault", {31'd0, lsu_fault}, 32'd1);
      chk("timeout rdata", lsu_rdata, 32'd0);

      // reset in the second REQ cycle
      lsu_start = 1'b1; lsu_is_store = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h0000_0300;
      mem_ack = 1'b0;
      @(posedge clk); #1;
      lsu_start = 1'b0;
      exp_busy = 1'b1; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h0000_0300; exp_wmask = 4'd0;
      @(posedge clk); #1;
      chk_en = 1'b0;
      chk("req before reset", {31'd0, mem_req}, 32'd1);
      rst = 1'b1;
      #1;
      chk("req after reset", {31'd0, mem_req}, 32'd0);
      chk("busy after reset", {31'd0, lsu_busy}, 32'd0);
      @(posedge clk); #1;
      chk("no done in reset", {31'd0, lsu_done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      set_idle();
      exp_rdata = 32'd0; exp_fault = 1'b0; exp_rchk = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      txn(1'b1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D, 1, 32'd0);
      chk("sw wmask", {28'd0, obs_wmask}, 32'h0000_000F);
      chk("sw wdata", obs_wdata, 32'hCAFE_F00D);
      chk("sw fault", {31'd0, lsu_fault}, 32'd0);

      for (int i = 0; i < 150; i++) begin
         int dly;
         dly = ($urandom % 8 == 0) ? -1 : int'($urandom_range(0, 5));
         txn(1'($urandom % 2), 3'($urandom), $urandom, $urandom, dly, $urandom);
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage of the multicycle RV32I core. It consumes load/store requests issued by the core controller in EXECUTE and drives the data-memory bus with a req/ack handshake. It returns byte/half/word load results, correctly aligned and extended, to the writeback path. The core sits in WAIT_MEM while this block is busy.

Parameters:
TIMEOUT_CYCLES, 16, max cycles mem_req may stay high without mem_ack before a fault; 0 disables the timeout.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
lsu_start  in  1  one-cycle request pulse from controller
lsu_is_store  in  1  1 = store (S-type), 0 = load
lsu_funct3  in  3  access size/sign per FUNCT3_L*/FUNCT3_S* constants
lsu_addr  in  32  byte address (rs1 + imm)
lsu_wdata  in  32  store data (rs2)
lsu_busy  out  1  high from the cycle after start until done
lsu_done  out  1  one-cycle completion pulse
lsu_rdata  out  32  formatted load result; valid with done, held until next accepted start
lsu_fault  out  1  misaligned, illegal funct3 or timeout; valid with done, held like rdata
mem_req  out  1  bus request, held until ack
mem_we  out  1  write enable
mem_addr  out  32  word-aligned address ({lsu_addr[31:2],2'b00})
mem_wdata  out  32  store data shifted into its byte lanes
mem_wmask  out  4  byte-lane enables (bit i = bits 8i+7:8i)
mem_rdata  in  32  read data, valid only in the mem_ack cycle
mem_ack  in  1  bus acknowledge

Behaviour:
- Reset (async, immediate): state IDLE, every output 0, timeout counter 0. Asserting reset mid-transaction drops mem_req at once. No done pulse is produced for the aborted access.
- States: IDLE, REQ, RESP.
- IDLE: on lsu_start, register addr, funct3, is_store and wdata.
  - Legal and aligned request -> REQ.
  - Otherwise -> RESP with fault=1; mem_req is never asserted.
- Legal loads: funct3 in {000, 001, 010, 100, 101}. Legal stores: funct3 in {000, 001, 010}.
- Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
- REQ:
  - mem_req=1. mem_we, mem_addr, mem_wdata and mem_wmask are stable throughout.
  - mem_ack -> RESP; for loads, capture mem_rdata in the same cycle.
  - Counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES: drop mem_req, go to RESP with fault=1. A load that times out returns rdata=0.
- RESP: lsu_done=1 for exactly one cycle, then -> IDLE.
- Latency: start at cycle 0 -> mem_req from cycle 1. An ack in cycle k gives done in cycle k+1; zero-wait ack gives done in cycle 2. A fault detected at start gives done in cycle 1.
- mem_wmask: SB = 1<<addr[1:0]; SH = 4'b0011<<addr[1:0]; SW = 4'b1111. For loads, mem_wmask = 0 and mem_we = 0.
- mem_wdata: SB replicates wdata[7:0] into all 4 lanes; SH replicates wdata[15:0] into both halves; SW passes wdata through.
- Load formatting: select the byte or half by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- lsu_start while busy is ignored. mem_ack outside REQ is ignored.
- lsu_busy = (state != IDLE).

Decomposition:
- Add lsu_state_t {LSU_IDLE, LSU_REQ, LSU_RESP} to the shared types package.
- Reuse the existing FUNCT3_LB..FUNCT3_SW constants; no new opcode constants.
- Factor one combinational sub-module, load_align (rdata, addr[1:0], funct3 -> rdata32), so it can be unit-tested alone.
- Store lane formatting stays inline.

Test Plan:
- SB addr 0x0000_0103, wdata 0x1234_56AB, ack after 2 cycles -> mem_addr 0x100, wmask 4'b1000, mem_wdata 0xABAB_ABAB, we=1, done 1 cycle after ack, fault=0.
- LB addr 0x102, mem_rdata 0x1280_FF34 -> rdata 0xFFFF_FF80; repeat with LBU -> 0x0000_0080; LHU at 0x100 -> 0x0000_FF34.
- LH addr 0x102, mem_rdata 0x8001_0000, zero-wait ack -> done in cycle 2, rdata 0xFFFF_8001.
- LW addr 0x101 -> mem_req never high, done in cycle 1 with fault=1. Store funct3=011 -> same response.
- TIMEOUT_CYCLES=4, load, no ack -> mem_req high exactly 4 cycles then low, done with fault=1, rdata 0. A start issued during busy is ignored.
- Reset asserted in the 2nd REQ cycle -> mem_req/busy fall immediately, no done pulse. A new SW at 0x200 after release completes normally with wmask 4'b1111.
